// File: rtl/afe_emulator_if.sv
// ============================================================================
// Module      : afe_emulator_if
// Description : Controller <-> analog-front-end signal bundle (drive settings in, ADC code out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface afe_emulator_if;
    logic [3:0] LED_DRIVE;
    logic [6:0] DC_Comp;
    logic       LED_IR;
    logic       LED_RED;
    logic [3:0] PGA_Gain;
    logic       CLK_Filter;
    logic [7:0] ADC;
    logic       Sat;
    logic       Fault;
    logic       Settling;

    modport master (
        output LED_DRIVE, DC_Comp, LED_IR, LED_RED, PGA_Gain, CLK_Filter,
        input  ADC, Sat, Fault, Settling
    );

    modport slave (
        input  LED_DRIVE, DC_Comp, LED_IR, LED_RED, PGA_Gain, CLK_Filter,
        output ADC, Sat, Fault, Settling
    );
endinterface

`default_nettype wire

// File: rtl/afe_emulator.sv
// ============================================================================
// Module      : afe_emulator
// Description : Synthesizable pulse-oximeter AFE responder returning a synthetic PPG ADC code.
//               Optional macro FILTER_SYNC_EN gates ADC loads on CLK_Filter rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module afe_emulator #(
    parameter int IR_SCALE   = 16,
    parameter int RED_SCALE  = 12,
    parameter int DARK_LEVEL = 4,
    parameter int COMP_STEP  = 2,
    parameter int AC_PEAK    = 32,
    parameter int AC_DIV     = 4,
    parameter int SETTLE_CYC = 3
) (
    input  wire logic     CLK,
    input  wire logic     rst_n,
    afe_emulator_if.slave bus
);

    localparam logic [15:0] c_ir_scale   = IR_SCALE[15:0];
    localparam logic [15:0] c_red_scale  = RED_SCALE[15:0];
    localparam logic [15:0] c_dark_level = DARK_LEVEL[15:0];
    localparam logic [15:0] c_comp_step  = COMP_STEP[15:0];
    localparam logic [15:0] c_ac_peak    = AC_PEAK[15:0];
    localparam logic [15:0] c_div_last   = 16'(AC_DIV - 1);
    localparam logic [7:0]  c_settle     = SETTLE_CYC[7:0];

    typedef enum logic [1:0] {
        CH_DARK = 2'd0,
        CH_IR   = 2'd1,
        CH_RED  = 2'd2
    } chan_t;

    chan_t       w_chan;
    logic [16:0] w_settings;
    logic [16:0] r_prev_settings;
    logic [7:0]  r_settle_cnt;

    logic [15:0] r_presc;
    logic [15:0] r_ac;
    logic        r_dir_up;

    logic [15:0] w_drive;
    logic [15:0] w_raw;
    logic [15:0] r_raw;
    logic [15:0] w_comp;
    logic [15:0] w_sub;
    logic [15:0] w_gain;
    logic [15:0] w_amp;
    logic        w_sat;
    logic [7:0]  w_out8;
    logic [7:0]  r_out8;
    logic        r_out_sat;

    logic        r_fault;
    logic [7:0]  r_adc;
    logic        r_sat;
    logic        w_load;

    always_comb begin
        w_chan = CH_DARK;
        if (bus.LED_IR && !bus.LED_RED) begin
            w_chan = CH_IR;
        end else if (bus.LED_RED && !bus.LED_IR) begin
            w_chan = CH_RED;
        end
    end

    assign w_settings = {w_chan, bus.LED_DRIVE, bus.DC_Comp, bus.PGA_Gain};

    // Triangle AC: one step per prescaler wrap, turning around at AC_PEAK and 0.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= 16'd0;
            r_ac     <= 16'd0;
            r_dir_up <= 1'b1;
        end else if (r_presc == c_div_last) begin
            r_presc <= 16'd0;
            if (c_ac_peak != 16'd0) begin
                if (r_dir_up) begin
                    r_ac <= r_ac + 16'd1;
                    if (r_ac + 16'd1 == c_ac_peak) begin
                        r_dir_up <= 1'b0;
                    end
                end else begin
                    r_ac <= r_ac - 16'd1;
                    if (r_ac - 16'd1 == 16'd0) begin
                        r_dir_up <= 1'b1;
                    end
                end
            end
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    assign w_drive = {12'd0, bus.LED_DRIVE};

    always_comb begin
        w_raw = c_dark_level;
        if (w_chan == CH_IR) begin
            w_raw = w_drive * c_ir_scale + ((r_ac * w_drive) >> 3);
        end else if (w_chan == CH_RED) begin
            w_raw = w_drive * c_red_scale + ((r_ac * w_drive) >> 3);
        end
    end

    // Offset compensation floors at zero rather than wrapping.
    assign w_comp = {9'd0, bus.DC_Comp} * c_comp_step;
    assign w_sub  = (r_raw > w_comp) ? (r_raw - w_comp) : 16'd0;
    assign w_gain = {12'd0, bus.PGA_Gain} + 16'd1;
    assign w_amp  = w_sub * w_gain;
    assign w_sat  = (w_amp > 16'd255);
    assign w_out8 = w_sat ? 8'hFF : w_amp[7:0];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_raw     <= 16'd0;
            r_out8    <= 8'd0;
            r_out_sat <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_raw     <= w_raw;
            r_out8    <= w_out8;
            r_out_sat <= w_sat;
            r_fault   <= bus.LED_IR & bus.LED_RED;
        end
    end

    // Any setting change restarts the settle window; reload takes priority over count-down.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_settings <= 17'd0;
            r_settle_cnt    <= c_settle;
        end else begin
            r_prev_settings <= w_settings;
            if (w_settings != r_prev_settings) begin
                r_settle_cnt <= c_settle;
            end else if (r_settle_cnt != 8'd0) begin
                r_settle_cnt <= r_settle_cnt - 8'd1;
            end
        end
    end

`ifdef FILTER_SYNC_EN
    logic r_filt_sync1;
    logic r_filt_sync2;
    logic r_filt_prev;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_sync1 <= 1'b0;
            r_filt_sync2 <= 1'b0;
            r_filt_prev  <= 1'b0;
        end else begin
            r_filt_sync1 <= bus.CLK_Filter;
            r_filt_sync2 <= r_filt_sync1;
            r_filt_prev  <= r_filt_sync2;
        end
    end

    assign w_load = (r_settle_cnt == 8'd0) && r_filt_sync2 && !r_filt_prev;
`else
    logic w_filter_unused;
    assign w_filter_unused = bus.CLK_Filter;
    assign w_load          = (r_settle_cnt == 8'd0);
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_adc <= 8'd0;
            r_sat <= 1'b0;
        end else if (w_load) begin
            r_adc <= r_out8;
            r_sat <= r_out_sat;
        end
    end

    assign bus.ADC      = r_adc;
    assign bus.Sat      = r_sat;
    assign bus.Fault    = r_fault;
    assign bus.Settling = (r_settle_cnt != 8'd0);

endmodule

`default_nettype wire
